mem_ctrl: RTL and testbench

Memory controller between the pipeline and the single 8-bit synchronous RAM. Serves the instruction-fetch stage (32-bit fetches) and the memory-access stage (byte/half/word loads and stores). Serialises each access into byte cycles, little-endian. Returns one-cycle completion pulses carrying the latched address, which the IF stage compares against its PC.

---
 rtl/mem_ctrl.sv | 143 ++++++++++++++
 tb/tb_mem_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller for the IF and MEM stages.
// Splits each access into little-endian byte cycles on one 8-bit RAM.
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_read,
  input  logic [31:0]       if_addr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_addr,
  input  logic [1:0]        mem_len,
  input  logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              if_ready,
  output logic [31:0]       if_addr_o,
  output logic [31:0]       if_data_o,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [2:0]  n;
  logic        src_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] acc;
  logic [31:0] word_next;
  logic [31:0] wshift;
  logic [2:0]  len_n;

  always_comb begin
    len_n = 3'd4;
    if (mem_len == 2'b00) len_n = 3'd1;
    else if (mem_len == 2'b01) len_n = 3'd2;
  end

  assign busy = (state != IDLE);

  // RAM data lags the address by one cycle, so lane cnt-1 lands now
  always_comb begin
    word_next = acc;
    if (state == RD) begin
      case (cnt)
        3'd1:    word_next[7:0]   = ram_din;
        3'd2:    word_next[15:8]  = ram_din;
        3'd3:    word_next[23:16] = ram_din;
        3'd4:    word_next[31:24] = ram_din;
        default: word_next = acc;
      endcase
    end
  end

  assign wshift = wdata >> {cnt[1:0], 3'b000};

  always_comb begin
    ram_a    = '0;
    ram_wr   = 1'b0;
    ram_dout = 8'h00;
    if (state != IDLE && cnt < n)
      ram_a = ADDR_W'(addr) + ADDR_W'(cnt);
    if (state == WR) begin
      ram_wr   = 1'b1;
      ram_dout = wshift[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      n         <= 3'd0;
      src_if    <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      acc       <= '0;
      if_ready  <= 1'b0;
      mem_done  <= 1'b0;
      if_addr_o <= '0;
      if_data_o <= '0;
      mem_rdata <= '0;
    end else begin
      if_ready <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 3'd0;
          acc <= '0;
          if (mem_read || mem_write) begin
            src_if <= 1'b0;
            addr   <= mem_addr;
            n      <= len_n;
            wdata  <= mem_wdata;
            state  <= mem_write ? WR : RD;
          end else if (if_read) begin
            src_if <= 1'b1;
            addr   <= if_addr;
            n      <= 3'd4;
            state  <= RD;
          end
        end
        RD: begin
          acc <= word_next;
          if (cnt == n) begin
            state <= IDLE;
            if (src_if) begin
              if_ready  <= 1'b1;
              if_addr_o <= addr;
              if_data_o <= word_next;
            end else begin
              mem_done  <= 1'b1;
              mem_rdata <= word_next;
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        WR: begin
          if (cnt == n - 3'd1) begin
            state    <= IDLE;
            mem_done <= 1'b1;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model plus a completion scoreboard.
// Expected done pulses carry their due cycle, source and data.
module tb_mem_ctrl;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_read;
  logic [31:0]   if_addr;
  logic          mem_read;
  logic          mem_write;
  logic [31:0]   mem_addr;
  logic [1:0]    mem_len;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          if_ready;
  logic [31:0]   if_addr_o;
  logic [31:0]   if_data_o;
  logic          mem_done;
  logic [31:0]   mem_rdata;
  logic [AW-1:0] ram_a;
  logic          ram_wr;
  logic [7:0]    ram_dout;
  logic [7:0]    ram_din;

  logic [7:0] ram [0:(1<<AW)-1];

  typedef struct {
    bit          is_if;
    int unsigned cyc;
    logic [31:0] addr;
    logic [31:0] data;
    bit          chk;
  } exp_t;

  exp_t sbq[$];
  int unsigned cyc = 0;
  int checks = 0;
  int failures = 0;

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .if_read(if_read), .if_addr(if_addr),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wdata(mem_wdata), .busy(busy),
    .if_ready(if_ready), .if_addr_o(if_addr_o),
    .if_data_o(if_data_o), .mem_done(mem_done),
    .mem_rdata(mem_rdata), .ram_a(ram_a),
    .ram_wr(ram_wr), .ram_dout(ram_dout),
    .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_wr) ram[ram_a] <= ram_dout;
    ram_din <= ram[ram_a];
  end

  // Completion monitor: every pulse must match the head of the queue
  always @(negedge clk) begin
    if (if_ready || mem_done) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done cyc=%0d if_ready=%b mem_done=%b",
                 cyc, if_ready, mem_done);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (if_ready !== e.is_if || mem_done !== !e.is_if ||
            cyc !== e.cyc ||
            (e.is_if && (if_addr_o !== e.addr || if_data_o !== e.data)) ||
            (!e.is_if && e.chk && mem_rdata !== e.data)) begin
          failures++;
          $display("FAIL done_check got if=%b cyc=%0d ia=%h id=%h rd=%h want if=%b cyc=%0d a=%h d=%h",
                   if_ready, cyc, if_addr_o, if_data_o, mem_rdata,
                   e.is_if, e.cyc, e.addr, e.data);
        end
      end
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d want 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic mem_op(input logic wr, input logic [31:0] a,
                        input logic [1:0] len, input logic [31:0] wd,
                        input int lat, input logic [31:0] ed);
    @(negedge clk);
    mem_read  = !wr;
    mem_write = wr;
    mem_addr  = a;
    mem_len   = len;
    mem_wdata = wd;
    sbq.push_back('{1'b0, cyc + lat, 32'h0, ed, !wr});
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (lat - 1) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || if_ready !== 1'b0 || mem_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags busy=%b if_ready=%b mem_done=%b want 0",
               busy, if_ready, mem_done);
    end
    checks++;
    if (if_addr_o !== 0 || if_data_o !== 0 || mem_rdata !== 0) begin
      failures++;
      $display("FAIL reset_data ia=%h id=%h rd=%h want 0",
               if_addr_o, if_data_o, mem_rdata);
    end
    checks++;
    if (ram_wr !== 1'b0 || ram_a !== '0 || ram_dout !== 8'h00) begin
      failures++;
      $display("FAIL reset_ram wr=%b a=%h d=%h want 0", ram_wr, ram_a, ram_dout);
    end
    reset = 1'b0;
  endtask

  task automatic test_if_fetch();
    int unsigned c;
    ram[17'h1000] = 8'h13;
    ram[17'h1001] = 8'h05;
    ram[17'h1002] = 8'h00;
    ram[17'h1003] = 8'h00;
    @(negedge clk);
    if_read = 1'b1;
    if_addr = 32'h1000;
    c = cyc;
    sbq.push_back('{1'b1, c + 6, 32'h1000, 32'h00000513, 1'b1});
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) if_read = 1'b0;
      checks++;
      if (busy !== (k <= 5)) begin
        failures++;
        $display("FAIL fetch_busy k=%0d got %b want %b", k, busy, k <= 5);
      end
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int unsigned c;
    int wr_cnt = 0;
    ram[17'h0] = 8'h11;
    ram[17'h1] = 8'h22;
    ram[17'h2] = 8'h33;
    ram[17'h3] = 8'h44;
    @(negedge clk);
    mem_write = 1'b1;
    mem_addr  = 32'h200;
    mem_len   = 2'b10;
    mem_wdata = 32'hDEADBEEF;
    if_read   = 1'b1;
    if_addr   = 32'h0;
    c = cyc;
    sbq.push_back('{1'b0, c + 5, 32'h0, 32'h0, 1'b0});
    sbq.push_back('{1'b1, c + 11, 32'h0, 32'h44332211, 1'b1});
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) mem_write = 1'b0;
      if (k == 6) if_read = 1'b0;
      if (ram_wr) wr_cnt++;
    end
    checks++;
    if (wr_cnt != 4) begin
      failures++;
      $display("FAIL write_cycles got %0d want 4", wr_cnt);
    end
    checks++;
    if ({ram[17'h203], ram[17'h202], ram[17'h201], ram[17'h200]}
        !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL write_bytes got %h%h%h%h want deadbeef",
               ram[17'h203], ram[17'h202], ram[17'h201], ram[17'h200]);
    end
    wait_drain();
  endtask

  task automatic test_mem_read();
    ram[17'h10] = 8'hF0;
    ram[17'h11] = 8'h80;
    ram[17'h12] = 8'h5A;
    ram[17'h13] = 8'hA5;
    mem_op(1'b0, 32'h10, 2'b00, 32'h0, 3, 32'h000000F0);
    mem_op(1'b0, 32'h10, 2'b01, 32'h0, 4, 32'h000080F0);
    mem_op(1'b0, 32'h10, 2'b11, 32'h0, 6, 32'hA55A80F0);
    wait_drain();
  endtask

  task automatic test_wrap_write();
    mem_op(1'b1, 32'h1FFFF, 2'b01, 32'h1234ABCD, 3, 32'h0);
    checks++;
    if (ram[17'h1FFFF] !== 8'hCD || ram[17'h0] !== 8'hAB) begin
      failures++;
      $display("FAIL wrap_write got top=%h low=%h want cd ab",
               ram[17'h1FFFF], ram[17'h0]);
    end
    mem_op(1'b0, 32'h1FFFF, 2'b01, 32'h0, 4, 32'h0000ABCD);
    wait_drain();
  endtask

  task automatic test_reset_abort();
    int unsigned c;
    @(negedge clk);
    if_read = 1'b1;
    if_addr = 32'h1000;
    c = cyc;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || if_data_o !== 0 || if_addr_o !== 0) begin
      failures++;
      $display("FAIL abort_state busy=%b ia=%h id=%h want 0",
               busy, if_addr_o, if_data_o);
    end
    sbq.push_back('{1'b1, c + 10, 32'h1000, 32'h00000513, 1'b1});
    for (int k = 5; k <= 10; k++) begin
      @(negedge clk);
      if (k == 5) if_read = 1'b0;
    end
    wait_drain();
  endtask

  task automatic test_write_abort();
    ram[17'h300] = 8'h00;
    ram[17'h301] = 8'h00;
    ram[17'h302] = 8'h00;
    ram[17'h303] = 8'h00;
    @(negedge clk);
    mem_write = 1'b1;
    mem_addr  = 32'h300;
    mem_len   = 2'b10;
    mem_wdata = 32'h87654321;
    @(negedge clk);
    mem_write = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({ram[17'h303], ram[17'h302], ram[17'h301], ram[17'h300]}
        !== 32'h00004321) begin
      failures++;
      $display("FAIL write_abort got %h%h%h%h want 00004321",
               ram[17'h303], ram[17'h302], ram[17'h301], ram[17'h300]);
    end
    checks++;
    if (busy !== 1'b0 || ram_wr !== 1'b0) begin
      failures++;
      $display("FAIL write_abort_idle busy=%b wr=%b want 0", busy, ram_wr);
    end
  endtask

  initial begin
    if_read   = 1'b0;
    if_addr   = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_len   = 2'b00;
    mem_wdata = '0;
    reset     = 1'b1;
    test_reset();
    test_if_fetch();
    test_back_to_back();
    test_mem_read();
    test_wrap_write();
    test_reset_abort();
    test_write_abort();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
